md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- E-stage multiply/divide unit of the 5-stage MIPS pipeline.
- Executes mult/multu/div/divu with fixed multi-cycle latency, plus mthi/mtlo.
- Holds the architectural HI/LO registers and drives E_Busy, which the D-stage stall unit uses to hold md/mf/mt instructions in D.
- mfhi/mflo read HI/LO directly from this block's outputs.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu.
- DIV_CYCLES, 10, busy cycles for div/divu.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Start  in  1  E-stage instruction is an md/mt op; qualifies MDOp
- MDOp  in  3  operation select: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO
- A  in  32  forwarded rs value
- B  in  32  forwarded rt value
- HI  out  32  HI register
- LO  out  32  LO register
- Busy  out  1  Start-with-mult/div OR internal busy flag (feeds stall unit E_Busy)

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high.
- Reset: HI=0, LO=0, busy_reg=0, cnt=0. Reset mid-operation aborts the operation: result discarded, Busy=0 the next cycle.
- Two-state FSM on busy_reg:
  - IDLE -> RUN on a clk edge with Start=1 and MDOp in {MULT, MULTU, DIV, DIVU}, busy_reg=0, reset=0.
  - That edge latches A and B, latches the op, and loads cnt = MULT_CYCLES or DIV_CYCLES.
- RUN: cnt decrements each edge. On the edge where cnt==1, commit HI/LO, set busy_reg=0, return to IDLE.
- Latency: Start in cycle t. Busy=1 in cycles t..t+N (N = cycles parameter). HI/LO carry the new value and Busy=0 from cycle t+N+1.
- Busy is combinational: Start & (MDOp is mult/div) | busy_reg. This ensures a following md/mf/mt instruction in D stalls already in cycle t.
- mult: signed 32x32 -> 64; HI=prod[63:32], LO=prod[31:0].
- multu: same as mult, unsigned.
- div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend (A).
- divu: unsigned quotient and remainder.
- Divide by zero: HI/LO unchanged at commit. Busy timing is identical to a normal divide.
- Signed overflow (0x80000000 / -1): LO=0x80000000, HI=0.
- MTHI/MTLO with Start=1 and busy_reg=0: HI (resp. LO) <= A on that edge; Busy never asserts.
- Start=1 while busy_reg=1: ignored; no operand capture, no HI/LO write. The stall unit guarantees this does not occur; the behaviour is defined for robustness.
- Operands are captured at start. A and B changing during RUN have no effect.
- Start=1 with an undefined MDOp: no effect.
- HI/LO outputs are registered; no combinational path from A or B to HI/LO.
- Arithmetic may be computed combinationally from the latched operands and written at commit; no iterative divider is required.

Decomposition:
- MD_* opcode constants (3-bit) go in the shared const.v include, alongside the GRFA3_* encodings.
- The MULT/DIV cycle defaults also go there as macros.
- No sub-module needed. The optional signed-divide helper stays inline as a function in md_unit.

Test Plan:
1. reset; Start=1, MULT, A=0xFFFFFFFE (-2), B=3 -> Busy=1 cycles t..t+5; cycle t+6: HI=0xFFFFFFFF, LO=0xFFFFFFFA, Busy=0.
2. MULTU, A=0xFFFFFFFF, B=2 -> after 6 cycles HI=0x00000001, LO=0xFFFFFFFE.
3. DIV, A=0xFFFFFFF8 (-8), B=3 -> Busy for 11 cycles (t..t+10); then LO=0xFFFFFFFE, HI=0xFFFFFFFE. DIVU of the same operands -> LO=0x55555552, HI=0x00000002.
4. MTHI A=0x12345678 -> HI updated the next cycle, Busy never high. Then DIV with B=0 -> Busy 11 cycles, HI/LO unchanged (HI=0x12345678).
5. Start DIV, assert reset in cycle t+4 -> Busy=0 and HI=LO=0 from t+5; no later commit.
6. Start MULT, then Start=1 MTLO A=0xAAAA at t+2 (busy) -> ignored; LO ends at the mult result. A and B toggled during RUN -> result unaffected.

Source files
------------

// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - opcode encodings, latency defaults and FSM states for the multiply/divide unit
package md_unit_pkg;

    // MDOp encodings; 3'd6 and 3'd7 are undefined and have no effect
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Default busy lengths (cycles after the start cycle)
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for the four ops that occupy the unit for multiple cycles
    function automatic logic is_md_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage request/result bundle between the pipeline and the multiply/divide unit
//
// Signals:
//   Start  - E-stage instruction is an md/mt op; qualifies MDOp
//   MDOp   - operation select (MD_* encodings)
//   A, B   - forwarded rs / rt values
//   HI, LO - architectural HI/LO registers
//   Busy   - unit occupied; drives the D-stage stall (E_Busy)
interface md_unit_if;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;

    modport master (
        output Start, MDOp, A, B,
        input  HI, LO, Busy
    );

    modport slave (
        input  Start, MDOp, A, B,
        output HI, LO, Busy
    );
endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - E-stage multiply/divide unit holding HI/LO with fixed multi-cycle latency
//
// Ports:
//   clk   - clock
//   reset - synchronous, active-high; aborts any operation in flight and clears HI/LO
//   md    - md_unit_if.slave: Start/MDOp/A/B in, HI/LO/Busy out
//
// A mult/div started in cycle t keeps Busy high for cycles t..t+N and the
// result is visible on HI/LO from cycle t+N+1. Arithmetic is evaluated
// combinationally from the operands captured at start and written at commit.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      w_hi_nxt;
    logic [31:0]      w_lo_nxt;

    logic             w_arith_op;
    logic             w_launch;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [63:0]      w_div_s;
    logic [31:0]      w_divu_q;
    logic [31:0]      w_divu_r;

    // Signed divide returning {remainder, quotient}. The one overflowing case
    // is pinned explicitly so the result does not depend on tool behaviour.
    function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0000_0000;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    assign w_arith_op = is_md_arith(md.MDOp);
    assign w_launch   = md.Start && w_arith_op && (r_state == ST_IDLE);

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'h0, r_a} * {32'h0, r_b};
    assign w_div_s  = sdiv(r_a, r_b);
    assign w_divu_q = r_a / r_b;
    assign w_divu_r = r_a % r_b;

    // Busy rises combinationally with Start so a dependent md/mf/mt in D stalls in cycle t
    assign md.Busy = (md.Start && w_arith_op) || (r_state == ST_RUN);
    assign md.HI   = r_hi;
    assign md.LO   = r_lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= MD_MULT;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            if (w_launch) begin
                r_op <= md.MDOp;
                r_a  <= md.A;
                r_b  <= md.B;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (md.Start) begin
                    if (w_arith_op) begin
                        w_state_nxt = ST_RUN;
                        w_cnt_nxt   = (md.MDOp == MD_MULT || md.MDOp == MD_MULTU)
                                      ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                    end else if (md.MDOp == MD_MTHI) begin
                        w_hi_nxt = md.A;
                    end else if (md.MDOp == MD_MTLO) begin
                        w_lo_nxt = md.A;
                    end
                end
            end
            ST_RUN: begin
                // Start is ignored here; only the countdown and commit happen
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                    case (r_op)
                        MD_MULT:  {w_hi_nxt, w_lo_nxt} = w_prod_s;
                        MD_MULTU: {w_hi_nxt, w_lo_nxt} = w_prod_u;
                        MD_DIV:   if (r_b != 32'h0) {w_hi_nxt, w_lo_nxt} = w_div_s;
                        MD_DIVU:  if (r_b != 32'h0) {w_hi_nxt, w_lo_nxt} = {w_divu_r, w_divu_q};
                        default:  ;
                    endcase
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - self-checking bench for md_unit with a behavioural HI/LO reference model
module tb_md_unit;
    import md_unit_pkg::*;

    logic clk = 1'b0;
    logic reset;

    md_unit_if u_if ();

    md_unit #(
        .MULT_CYCLES(MD_MULT_CYCLES),
        .DIV_CYCLES (MD_DIV_CYCLES)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .md   (u_if)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_hi  = 32'h0;
    logic [31:0] exp_lo  = 32'h0;

    // Reference: architectural MIPS semantics in 64-bit integer arithmetic
    task automatic ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            MD_MULT:  begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            MD_MULTU: begin up = ua * ub; exp_hi = up[63:32]; exp_lo = up[31:0]; end
            MD_DIV:   if (b != 0) begin q = sa / sb; r = sa % sb; exp_lo = q[31:0]; exp_hi = r[31:0]; end
            MD_DIVU:  if (b != 0) begin up = ua / ub; exp_lo = up[31:0]; up = ua % ub; exp_hi = up[31:0]; end
            MD_MTHI:  exp_hi = a;
            MD_MTLO:  exp_lo = a;
            default:  ;
        endcase
    endtask

    // Issue one mult/div and follow it to completion; optionally try an MTLO while busy
    task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject_mtlo, input string name);
        int          lat, busy_cycles;
        bit          early;
        logic [31:0] old_hi, old_lo;
        lat    = (op == MD_MULT || op == MD_MULTU) ? MD_MULT_CYCLES : MD_DIV_CYCLES;
        old_hi = exp_hi;
        old_lo = exp_lo;
        early  = 1'b0;
        @(negedge clk);
        u_if.Start = 1'b1; u_if.MDOp = op; u_if.A = a; u_if.B = b;
        #1;
        busy_cycles = (u_if.Busy === 1'b1) ? 1 : 0;
        ref_op(op, a, b);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (inject_mtlo && k == 2) begin
                u_if.Start = 1'b1; u_if.MDOp = MD_MTLO; u_if.A = 32'h0000_AAAA;
            end else begin
                u_if.Start = 1'b0; u_if.A = $urandom; u_if.B = $urandom;
            end
            #1;
            if (u_if.Busy !== 1'b1) break;
            busy_cycles++;
            if (u_if.HI !== old_hi || u_if.LO !== old_lo) early = 1'b1;
        end
        n_tests++;
        if (busy_cycles != lat + 1) begin
            n_fail++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cycles, lat + 1);
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("FAIL %s early_hilo_change: got 1 expected 0", name);
        end
        n_tests++;
        if (u_if.HI !== exp_hi || u_if.LO !== exp_lo) begin
            n_fail++;
            $display("FAIL %s result: got HI=%h LO=%h expected HI=%h LO=%h",
                     name, u_if.HI, u_if.LO, exp_hi, exp_lo);
        end
    endtask

    // One-cycle mt or undefined op; Busy must stay low throughout
    task automatic do_mt(input logic [2:0] op, input logic [31:0] a, input string name);
        bit busy_seen;
        @(negedge clk);
        u_if.Start = 1'b1; u_if.MDOp = op; u_if.A = a; u_if.B = $urandom;
        #1;
        busy_seen = (u_if.Busy !== 1'b0);
        ref_op(op, a, 32'h0);
        @(negedge clk);
        u_if.Start = 1'b0; u_if.A = $urandom;
        #1;
        busy_seen = busy_seen || (u_if.Busy !== 1'b0);
        n_tests++;
        if (busy_seen) begin
            n_fail++;
            $display("FAIL %s busy: got 1 expected 0", name);
        end
        n_tests++;
        if (u_if.HI !== exp_hi || u_if.LO !== exp_lo) begin
            n_fail++;
            $display("FAIL %s result: got HI=%h LO=%h expected HI=%h LO=%h",
                     name, u_if.HI, u_if.LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        u_if.Start = 1'b0; u_if.MDOp = MD_MULT; u_if.A = 32'h0; u_if.B = 32'h0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (u_if.HI !== 32'h0 || u_if.LO !== 32'h0 || u_if.Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got HI=%h LO=%h Busy=%b expected 0 0 0", u_if.HI, u_if.LO, u_if.Busy);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
    endtask

    task automatic test_mult();
        do_md(MD_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 1'b0, "mult_neg");
        do_md(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, "multu_max");
        do_md(MD_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
    endtask

    task automatic test_div();
        do_md(MD_DIV,  32'hFFFF_FFF8, 32'h0000_0003, 1'b0, "div_neg");
        do_md(MD_DIVU, 32'hFFFF_FFF8, 32'h0000_0003, 1'b0, "divu");
        do_md(MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
        do_md(MD_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 1'b0, "div_negdivisor");
    endtask

    task automatic test_mt_divzero();
        do_mt(MD_MTHI, 32'h1234_5678, "mthi");
        do_mt(MD_MTLO, 32'h0BAD_F00D, "mtlo");
        do_md(MD_DIV,  32'h0000_0064, 32'h0000_0000, 1'b0, "div_by_zero");
        do_md(MD_DIVU, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "divu_by_zero");
        do_mt(3'd6, 32'hDEAD_BEEF, "undef_op6");
        do_mt(3'd7, 32'hDEAD_BEEF, "undef_op7");
    endtask

    task automatic test_reset_abort();
        bit late_change;
        @(negedge clk);
        u_if.Start = 1'b1; u_if.MDOp = MD_DIV; u_if.A = 32'd100; u_if.B = 32'd7;
        @(negedge clk);
        u_if.Start = 1'b0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        #1;
        n_tests++;
        if (u_if.Busy !== 1'b0 || u_if.HI !== 32'h0 || u_if.LO !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_abort: got Busy=%b HI=%h LO=%h expected 0 0 0", u_if.Busy, u_if.HI, u_if.LO);
        end
        late_change = 1'b0;
        repeat (15) begin
            @(negedge clk);
            #1;
            if (u_if.Busy !== 1'b0 || u_if.HI !== 32'h0 || u_if.LO !== 32'h0) late_change = 1'b1;
        end
        n_tests++;
        if (late_change) begin
            n_fail++;
            $display("FAIL reset_abort_late_commit: got 1 expected 0");
        end
    endtask

    task automatic test_busy_ignore();
        do_md(MD_MULT, 32'h0000_1234, 32'hFFFF_0001, 1'b1, "mult_ignore_mtlo");
        do_md(MD_DIVU, 32'h7777_7777, 32'h0000_0010, 1'b1, "divu_ignore_mtlo");
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 5));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(1, 9)); end
                default: ;
            endcase
            if (op == MD_MTHI || op == MD_MTLO) do_mt(op, a, "rand_mt");
            else do_md(op, a, b, 1'b0, "rand_md");
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_divzero();
        test_reset_abort();
        test_busy_ignore();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
